// File: rtl/cos_lut_sequencer.sv
// rtl/cos_lut_sequencer.sv - I/Q carrier sequencer time-sharing one registered cosine table
module cos_lut_sequencer #(
    parameter int PHASE_W = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               sample_tick,
    input  logic [PHASE_W-1:0] ftw_in,
    input  logic               ftw_load,
    input  logic               phase_clr,
    input  logic               ovr_clr,
    output logic [3:0]         tbl_addr,
    input  logic [7:0]         tbl_data,
    output logic [7:0]         i_out,
    output logic [7:0]         q_out,
    output logic               iq_valid,
    output logic               busy,
    output logic               overrun
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD_I  = 2'd1,
        ST_RD_Q  = 2'd2,
        ST_CAP_Q = 2'd3
    } state_t;

    state_t             r_state;
    logic [PHASE_W-1:0] r_acc;
    logic [PHASE_W-1:0] r_ftw;
    logic [3:0]         r_tbl_addr;
    logic [7:0]         r_i_hold;
    logic [7:0]         r_i_out;
    logic [7:0]         r_q_out;
    logic               r_iq_valid;
    logic               r_busy;
    logic               r_overrun;

    logic               w_tick_en;
    logic               w_accept;
    logic               w_drop;

    // A tick only counts while enabled; it starts a sample in IDLE and is dropped otherwise
    assign w_tick_en = enable & sample_tick;
    assign w_accept  = w_tick_en & (r_state == ST_IDLE);
    assign w_drop    = w_tick_en & (r_state != ST_IDLE);

    // Sequencer FSM: phase accumulator, table address walk, I/Q capture and overrun tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_acc      <= '0;
            r_ftw      <= '0;
            r_tbl_addr <= 4'd0;
            r_i_hold   <= 8'd0;
            r_i_out    <= 8'd0;
            r_q_out    <= 8'd0;
            r_iq_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_iq_valid <= 1'b0;

            // New tuning word takes effect from the next edge; this edge still adds the old one
            if (ftw_load) begin
                r_ftw <= ftw_in;
            end

            // Set beats clear so a dropped tick is never lost
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (ovr_clr) begin
                r_overrun <= 1'b0;
            end

            // Clear wins over the increment; the address below still uses the pre-clear phase
            if (phase_clr) begin
                r_acc <= '0;
            end else if (w_accept) begin
                r_acc <= r_acc + r_ftw;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_tbl_addr <= r_acc[PHASE_W-1 -: 4];
                        r_busy     <= 1'b1;
                        r_state    <= ST_RD_I;
                    end
                end
                ST_RD_I: begin
                    // Minus 90 degrees on a 16-entry circle is +12 modulo 16
                    r_tbl_addr <= r_tbl_addr + 4'd12;
                    r_state    <= ST_RD_Q;
                end
                ST_RD_Q: begin
                    r_i_hold <= tbl_data;
                    r_state  <= ST_CAP_Q;
                end
                ST_CAP_Q: begin
                    r_i_out    <= r_i_hold;
                    r_q_out    <= tbl_data;
                    r_iq_valid <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tbl_addr = r_tbl_addr;
    assign i_out    = r_i_out;
    assign q_out    = r_q_out;
    assign iq_valid = r_iq_valid;
    assign busy     = r_busy;
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_cos_lut_sequencer.sv
// tb/tb_cos_lut_sequencer.sv - scoreboard bench for cos_lut_sequencer
module tb_cos_lut_sequencer;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        sample_tick;
    logic [23:0] ftw_in;
    logic        ftw_load;
    logic        phase_clr;
    logic        ovr_clr;
    logic [3:0]  tbl_addr;
    logic [7:0]  tbl_data;
    logic [7:0]  i_out;
    logic [7:0]  q_out;
    logic        iq_valid;
    logic        busy;
    logic        overrun;

    int unsigned cyc;
    int          vectors;
    int          miscompares;

    typedef struct {
        logic [7:0]  i;
        logic [7:0]  q;
        int unsigned cyc;
    } exp_t;

    exp_t sb[$];

    cos_lut_sequencer #(.PHASE_W(24)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .sample_tick (sample_tick),
        .ftw_in      (ftw_in),
        .ftw_load    (ftw_load),
        .phase_clr   (phase_clr),
        .ovr_clr     (ovr_clr),
        .tbl_addr    (tbl_addr),
        .tbl_data    (tbl_data),
        .i_out       (i_out),
        .q_out       (q_out),
        .iq_valid    (iq_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    // Hand-derived 127*cos(k*22.5 deg), truncated toward zero
    function automatic logic [7:0] cos_tab(input logic [3:0] a);
        case (a)
            4'd0:  return 8'h7f;
            4'd1:  return 8'h75;
            4'd2:  return 8'h59;
            4'd3:  return 8'h30;
            4'd4:  return 8'h00;
            4'd5:  return 8'hd0;
            4'd6:  return 8'ha7;
            4'd7:  return 8'h8b;
            4'd8:  return 8'h81;
            4'd9:  return 8'h8b;
            4'd10: return 8'ha7;
            4'd11: return 8'hd0;
            4'd12: return 8'h00;
            4'd13: return 8'h30;
            4'd14: return 8'h59;
            default: return 8'h75;
        endcase
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered-read table model
    always @(posedge clk) tbl_data <= cos_tab(tbl_addr);

    // Monitor: every iq_valid must match the oldest expectation, in value and in cycle
    always @(negedge clk) begin
        if (rst_n && iq_valid) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_iq: got i=%02h q=%02h at cycle %0d, required no iq_valid", i_out, q_out, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (i_out !== e.i || q_out !== e.q || cyc != e.cyc) begin
                    miscompares++;
                    $display("FAIL iq_sample: got i=%02h q=%02h cycle %0d, required i=%02h q=%02h cycle %0d",
                             i_out, q_out, cyc, e.i, e.q, e.cyc);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic expect_sample(input logic [7:0] ei, input logic [7:0] eq);
        exp_t e;
        e.i   = ei;
        e.q   = eq;
        e.cyc = cyc + 4;
        sb.push_back(e);
    endtask

    // Accepted tick at table address a; expectation comes from the hand table
    task automatic tick_at(input logic [3:0] a);
        logic [3:0] aq;
        aq = a + 4'd12;
        expect_sample(cos_tab(a), cos_tab(aq));
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
    endtask

    task automatic load_ftw(input logic [23:0] w, input logic clr);
        ftw_in    = w;
        ftw_load  = 1'b1;
        phase_clr = clr;
        step(1);
        ftw_load  = 1'b0;
        phase_clr = 1'b0;
    endtask

    initial begin
        cyc         = 0;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        enable      = 1'b1;
        sample_tick = 1'b0;
        ftw_in      = '0;
        ftw_load    = 1'b0;
        phase_clr   = 1'b0;
        ovr_clr     = 1'b0;

        // Reset state
        step(3);
        check("rst_tbl_addr", {28'd0, tbl_addr}, 32'd0);
        check("rst_i_out", {24'd0, i_out}, 32'd0);
        check("rst_q_out", {24'd0, q_out}, 32'd0);
        check("rst_iq_valid", {31'd0, iq_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        rst_n = 1'b1;
        step(1);

        // Step +1: 17 samples walk the full circle and wrap back to address 0
        load_ftw(24'h100000, 1'b0);
        expect_sample(8'h7f, 8'h00);
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        check("busy_after_tick", {31'd0, busy}, 32'd1);
        step(2);
        check("busy_n3", {31'd0, busy}, 32'd1);
        step(1);
        check("busy_n4", {31'd0, busy}, 32'd0);
        step(4);
        for (int k = 1; k < 17; k++) begin
            tick_at(k[3:0]);
            step(7);
        end
        check("sb_drained_step1", sb.size(), 32'd0);

        // Step -1 wrap from a cleared phase
        load_ftw(24'hF00000, 1'b1);
        expect_sample(8'h7f, 8'h00);
        sample_tick = 1'b1; step(1); sample_tick = 1'b0; step(7);
        expect_sample(8'h75, 8'hd0);
        sample_tick = 1'b1; step(1); sample_tick = 1'b0; step(7);
        expect_sample(8'h59, 8'ha7);
        sample_tick = 1'b1; step(1); sample_tick = 1'b0; step(7);

        // Overrun: back-to-back ticks (phase now 0xD00000, a=13)
        tick_at(4'd13);
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        check("overrun_set", {31'd0, overrun}, 32'd1);
        step(6);
        ovr_clr = 1'b1;
        step(1);
        ovr_clr = 1'b0;
        check("overrun_clr", {31'd0, overrun}, 32'd0);
        tick_at(4'd12);
        sample_tick = 1'b1;
        ovr_clr     = 1'b1;
        step(1);
        sample_tick = 1'b0;
        ovr_clr     = 1'b0;
        check("overrun_set_wins", {31'd0, overrun}, 32'd1);
        step(6);
        ovr_clr = 1'b1;
        step(1);
        ovr_clr = 1'b0;

        // FTW and clear collisions: bring phase to 0x200000 with ftw 0x100000
        load_ftw(24'h200000, 1'b1);
        tick_at(4'd0);
        step(7);
        load_ftw(24'h100000, 1'b0);
        expect_sample(8'h59, 8'h59);
        ftw_in      = 24'h300000;
        ftw_load    = 1'b1;
        sample_tick = 1'b1;
        step(1);
        ftw_load    = 1'b0;
        sample_tick = 1'b0;
        step(7);
        tick_at(4'd3);
        step(7);
        tick_at(4'd6);
        step(7);
        expect_sample(8'h8b, 8'hd0);
        phase_clr   = 1'b1;
        sample_tick = 1'b1;
        step(1);
        phase_clr   = 1'b0;
        sample_tick = 1'b0;
        step(7);
        tick_at(4'd0);
        step(7);
        check("sb_drained_coll", sb.size(), 32'd0);

        // Reset during RD_Q aborts the sample
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        step(1);
        rst_n = 1'b0;
        #1;
        check("rstmid_tbl_addr", {28'd0, tbl_addr}, 32'd0);
        check("rstmid_i_out", {24'd0, i_out}, 32'd0);
        check("rstmid_q_out", {24'd0, q_out}, 32'd0);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_iq_valid", {31'd0, iq_valid}, 32'd0);
        step(2);
        rst_n = 1'b1;
        step(8);
        load_ftw(24'h100000, 1'b0);
        tick_at(4'd0);
        step(7);

        // Enable low: ticks ignored, no overrun
        enable = 1'b0;
        sample_tick = 1'b1;
        step(2);
        sample_tick = 1'b0;
        check("dis_busy", {31'd0, busy}, 32'd0);
        check("dis_overrun", {31'd0, overrun}, 32'd0);
        step(6);
        // Enable dropped during RD_I: the sample still completes (phase 0x100000, a=1)
        enable = 1'b1;
        tick_at(4'd1);
        enable = 1'b0;
        step(7);
        check("sb_drained_end", sb.size(), 32'd0);
        enable = 1'b1;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
